// File: rtl/defines_package.sv
// Shared geometry/colour types and the wireframe SRAM address width used by the
// raster pipeline blocks.
package defines_package;

    localparam int WIREFRAME_ADDR_SIZE = 8;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] z;
    } Vertex3D;

    typedef struct packed {
        Vertex3D v0;
        Vertex3D v1;
        Vertex3D v2;
    } Triangle3D;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } Color;

endpackage

// File: rtl/raster_scheduler_if.sv
// Bus bundle for raster_scheduler: triangle submit handshake, rasterizer
// command/plot channel and wireframe SRAM write port.
interface raster_scheduler_if;

    logic                                            tri_valid;
    defines_package::Triangle3D                      tri_in;
    defines_package::Color                           color_in;
    logic                                            tri_ready;

    logic                                            r_start;
    defines_package::Triangle3D                      r_triangle;
    defines_package::Color                           r_color;
    logic                                            r_done;

    logic                                            r_write_en;
    logic                                            r_wf_data;
    logic [defines_package::WIREFRAME_ADDR_SIZE-1:0] r_addr;

    logic                                            sram_write_en;
    logic                                            sram_wf_data;
    logic [defines_package::WIREFRAME_ADDR_SIZE-1:0] sram_addr;

    // Upstream producer / rasterizer / SRAM side.
    modport master (
        output tri_valid, tri_in, color_in, r_done, r_write_en, r_wf_data, r_addr,
        input  tri_ready, r_start, r_triangle, r_color,
        input  sram_write_en, sram_wf_data, sram_addr
    );

    // Scheduler side.
    modport slave (
        input  tri_valid, tri_in, color_in, r_done, r_write_en, r_wf_data, r_addr,
        output tri_ready, r_start, r_triangle, r_color,
        output sram_write_en, sram_wf_data, sram_addr
    );

endinterface

// File: rtl/raster_scheduler.sv
// Triangle queue and issue FSM feeding a single rasterizer, with an optional
// wireframe-SRAM clear sweep enabled by defining RASTER_SCHED_CLEAR_EN.
module raster_scheduler
    import defines_package::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               frame_start,
    raster_scheduler_if.slave  bus,
    output logic               busy,
    output logic [15:0]        tri_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
`ifdef RASTER_SCHED_CLEAR_EN
        , S_CLEAR = 2'd3
`endif
    } state_e;

    typedef struct packed {
        Triangle3D geom;
        Color      shade;
    } entry_t;

    state_e           state_q, state_d;
    entry_t           fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    Triangle3D        r_triangle_q, r_triangle_d;
    Color             r_color_q, r_color_d;
    logic [15:0]      tri_count_q, tri_count_d;

`ifdef RASTER_SCHED_CLEAR_EN
    localparam int N = WIREFRAME_ADDR_SIZE;
    logic             clear_pending_q, clear_pending_d;
    logic [N-1:0]     clr_addr_q, clr_addr_d;
`endif

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic clear_req;
    entry_t head;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign push  = bus.tri_valid && !full;
    assign head  = fifo_mem[rd_ptr_q];

`ifdef RASTER_SCHED_CLEAR_EN
    assign clear_req = clear_pending_q;
`else
    assign clear_req = 1'b0;
`endif

    // A pending clear always wins over issuing the next queued triangle.
    assign pop = (state_q == S_IDLE) && !clear_req && !empty;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        r_triangle_d = r_triangle_q;
        r_color_d    = r_color_q;
        tri_count_d  = tri_count_q;
`ifdef RASTER_SCHED_CLEAR_EN
        clear_pending_d = clear_pending_q;
        clr_addr_d      = clr_addr_q;
`endif

        case (state_q)
            S_IDLE: begin
`ifdef RASTER_SCHED_CLEAR_EN
                if (clear_pending_q) begin
                    state_d         = S_CLEAR;
                    clear_pending_d = 1'b0;
                    tri_count_d     = '0;
                end else
`endif
                if (pop) begin
                    state_d      = S_ISSUE;
                    r_triangle_d = head.geom;
                    r_color_d    = head.shade;
                end
            end

            S_ISSUE: begin
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (bus.r_done) begin
                    tri_count_d = tri_count_q + 16'd1;
                    state_d     = S_IDLE;
                end
            end

`ifdef RASTER_SCHED_CLEAR_EN
            S_CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == '1) begin
                    state_d = S_IDLE;
                end
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A frame_start arriving on the cycle CLEAR is entered still queues another sweep.
`ifdef RASTER_SCHED_CLEAR_EN
        if (frame_start) begin
            clear_pending_d = 1'b1;
        end
`else
        if (frame_start) begin
            tri_count_d = '0;
        end
`endif
    end

    // NOTE: synchronous active-low reset; all state registers update with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            r_triangle_q <= '0;
            r_color_q    <= '0;
            tri_count_q  <= '0;
`ifdef RASTER_SCHED_CLEAR_EN
            clear_pending_q <= 1'b0;
            clr_addr_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            r_triangle_q <= r_triangle_d;
            r_color_q    <= r_color_d;
            tri_count_q  <= tri_count_d;
`ifdef RASTER_SCHED_CLEAR_EN
            clear_pending_q <= clear_pending_d;
            clr_addr_q      <= clr_addr_d;
`endif
        end
    end

    // NOTE: queue storage has no reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= '{geom: bus.tri_in, shade: bus.color_in};
        end
    end

    assign bus.tri_ready  = !full;
    assign bus.r_start    = (state_q == S_ISSUE);
    assign bus.r_triangle = r_triangle_q;
    assign bus.r_color    = r_color_q;
    assign tri_count      = tri_count_q;

`ifdef RASTER_SCHED_CLEAR_EN
    assign busy = (state_q != S_IDLE) || !empty || clear_pending_q;
`else
    assign busy = (state_q != S_IDLE) || !empty;
`endif

    always_comb begin
        bus.sram_write_en = bus.r_write_en;
        bus.sram_wf_data  = bus.r_wf_data;
        bus.sram_addr     = bus.r_addr;
`ifdef RASTER_SCHED_CLEAR_EN
        if (state_q == S_CLEAR) begin
            bus.sram_write_en = 1'b1;
            bus.sram_wf_data  = 1'b0;
            bus.sram_addr     = clr_addr_q;
        end
`endif
    end

endmodule
